// File: rtl/sti_deserializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sti_deserializer_if                                             |
// | Purpose  : Frame read-out bus of the STI deserializer. Carries the head    |
// |            FIFO entry and its valid/ready handshake.                       |
// | Signals  : out_word  [31:0] head frame, right-aligned                      |
// |            out_len   [1:0]  length code (0=8,1=16,2=24,3=32 bits)          |
// |            out_err          head frame had an illegal bit count            |
// |            out_valid        FIFO not empty                                 |
// |            out_ready        consumer accepts the head entry                |
// | Modports : master = deserializer side, slave = consumer side               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sti_deserializer_if;
  logic [31:0] out_word;
  logic [1:0]  out_len;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_word,
    output out_len,
    output out_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_word,
    input  out_len,
    input  out_err,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/sti_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sti_deserializer                                                |
// | Purpose  : Serial receiver for the STI transmitter stream. Rebuilds each   |
// |            rx_valid-qualified bit burst into a right-aligned 32-bit word   |
// |            with length code and error flag, and queues it in a            |
// |            first-word-fall-through FIFO read via valid/ready.              |
// | Ports    : clk, reset (async, active-high)                                 |
// |            rx_data, rx_valid, rx_msb   serial input and bit order         |
// |            out_if (master)             frame read-out bus                 |
// |            overflow                    1-cycle pulse, frame dropped       |
// |            fifo_level [LW-1:0]         FIFO occupancy                      |
// |            frame_cnt [15:0], err_cnt [7:0]  only with STI_DESER_STATS_EN   |
// | Macro    : STI_DESER_STATS_EN adds saturating frame/error counters.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sti_deserializer #(
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_data,
  input  logic             rx_valid,
  input  logic             rx_msb,
  sti_deserializer_if.master out_if,
  output logic             overflow,
  output logic [LW-1:0]    fifo_level
`ifdef STI_DESER_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
`endif
);

  localparam int PW = LW - 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        ord_q, ord_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic        push;

  always_comb begin
    state_d = state_q;
    ord_d   = ord_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          state_d = SHIFT;
          ord_d   = rx_msb;
          cnt_d   = 6'd1;
          // Both bit orders land the first bit in sr[0] of a cleared register.
          sr_d    = {31'd0, rx_data};
        end
      end
      SHIFT: begin
        if (rx_valid) begin
          if (ord_q) begin
            sr_d = {sr_q[30:0], rx_data};
          end else if (!cnt_q[5]) begin
            sr_d[cnt_q[4:0]] = rx_data;
          end
          if (cnt_q != 6'd63) begin
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          push    = 1'b1;
          cnt_d   = 6'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ord_q   <= 1'b0;
      cnt_q   <= 6'd0;
      sr_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ord_q   <= ord_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame classification, evaluated while the terminating low cycle is seen
  // ---------------------------------------------------------------------------
  logic [31:0] fr_word;
  logic [1:0]  fr_len;
  logic        fr_err;

  always_comb begin
    fr_word = 32'd0;
    fr_len  = 2'd0;
    fr_err  = 1'b1;
    case (cnt_q)
      6'd8:  begin fr_word = {24'd0, sr_q[7:0]};  fr_len = 2'd0; fr_err = 1'b0; end
      6'd16: begin fr_word = {16'd0, sr_q[15:0]}; fr_len = 2'd1; fr_err = 1'b0; end
      6'd24: begin fr_word = {8'd0,  sr_q[23:0]}; fr_len = 2'd2; fr_err = 1'b0; end
      6'd32: begin fr_word = sr_q;                fr_len = 2'd3; fr_err = 1'b0; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [34:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full;
  logic          fifo_nempty;
  logic          pop;
  logic          push_ok;
  logic [34:0]   head;

  always_comb begin
    fifo_nempty = (level_q != '0);
    fifo_full   = (level_q == LW'(FIFO_DEPTH));
    pop         = fifo_nempty && out_if.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok     = push && (!fifo_full || pop);
    overflow_d  = push && fifo_full && !pop;
    wr_ptr_d    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d     = level_q + LW'(push_ok) - LW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible behind a non-zero level.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {fr_err, fr_len, fr_word};
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign out_if.out_valid = fifo_nempty;
  assign out_if.out_word  = fifo_nempty ? head[31:0]  : 32'd0;
  assign out_if.out_len   = fifo_nempty ? head[33:32] : 2'd0;
  assign out_if.out_err   = fifo_nempty ? head[34]    : 1'b0;
  assign overflow         = overflow_q;
  assign fifo_level       = level_q;

`ifdef STI_DESER_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics; dropped frames still count as completed.
  // ---------------------------------------------------------------------------
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (push && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (push && fr_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire
